fc_bias_sequencer: RTL

- Sequences reads of the FC bias ROM for one fully connected layer per command: FC1 (FC1_SIZE neurons) or FC2 (FC2_SIZE neurons).
- Drives the ROM's read_enable, fc_layer_select and addr.
- Absorbs the ROM's 1-cycle synchronous read latency.
- Presents biases in neuron order as a valid/ready stream to the FC accumulator/requantization stage, with a 2-entry skid buffer for backpressure.

---
 rtl/fc_bias_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fc_bias_sequencer.sv
// FC bias read sequencer: walks one FC layer of the bias ROM and
// streams the biases in neuron order through a 2-entry skid buffer.
module fc_bias_sequencer #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 74,
   parameter int FC1_SIZE = 64,
   parameter int FC2_SIZE = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     layer_sel,
   output logic                     busy,
   output logic                     done,
   output logic                     rom_read_enable,
   output logic                     rom_fc_layer_select,
   output logic [$clog2(DEPTH)-1:0] rom_addr,
   input  logic [WIDTH-1:0]         rom_bias_in,
   output logic                     bias_valid,
   input  logic                     bias_ready,
   output logic [WIDTH-1:0]         bias_data,
   output logic [6:0]               bias_idx,
   output logic                     bias_last
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t          state;
   logic            layer_r;
   logic [IW-1:0]   n_r;
   logic [IW-1:0]   last_idx;
   logic [IW-1:0]   issue_cnt;

   logic            infl;
   logic [IW-1:0]   infl_idx;

   logic [1:0]      count;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [IW-1:0]   i0;
   logic [IW-1:0]   i1;

   logic            push;
   logic            pop;
   logic            last_hs;
   logic [2:0]      load;

   assign last_idx = n_r - 7'd1;

   assign bias_valid = (count != 2'd0);
   assign bias_data  = d0;
   assign bias_idx   = i0;
   assign bias_last  = bias_valid & (i0 == last_idx);

   assign push    = infl;
   assign pop     = bias_valid & bias_ready;
   assign last_hs = pop & bias_last;

   // A pop this cycle frees a slot, so the issue decision may count it;
   // that is what keeps a bias per cycle flowing with ready held high.
   assign load = {1'b0, count} + {2'b0, infl} - {2'b0, pop};

   assign rom_read_enable     = reset & (state == S_RUN) & (load < 3'd2);
   assign rom_fc_layer_select = layer_r;
   assign rom_addr            = AW'(issue_cnt);

   // Command FSM: latch layer, walk the issue counter, wait for the last beat.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         layer_r   <= 1'b0;
         n_r       <= '0;
         issue_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  layer_r   <= layer_sel;
                  n_r       <= layer_sel ? IW'(FC2_SIZE) : IW'(FC1_SIZE);
                  issue_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= S_RUN;
               end
            end
            S_RUN: begin
               if (rom_read_enable) begin
                  issue_cnt <= issue_cnt + 7'd1;
                  if (issue_cnt == last_idx) begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (last_hs) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_FIN;
               end
            end
            S_FIN: begin
               // done cycle: a start here is deliberately not honoured
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Track the read in flight so its data can be tagged when it lands.
   always_ff @(posedge clk) begin
      if (!reset) begin
         infl     <= 1'b0;
         infl_idx <= '0;
      end else begin
         infl <= rom_read_enable;
         if (rom_read_enable) begin
            infl_idx <= issue_cnt;
         end
      end
   end

   // Two-entry skid buffer; entry 0 is always the head of the stream.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= 2'd0;
         d0    <= '0;
         d1    <= '0;
         i0    <= '0;
         i1    <= '0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  d0 <= rom_bias_in;
                  i0 <= infl_idx;
               end else begin
                  d1 <= rom_bias_in;
                  i1 <= infl_idx;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               d0    <= d1;
               i0    <= i1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  d0 <= rom_bias_in;
                  i0 <= infl_idx;
               end else begin
                  d0 <= d1;
                  i0 <= i1;
                  d1 <= rom_bias_in;
                  i1 <= infl_idx;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // An issued read must stay inside the selected layer.
   a_addr_bound: assert property (
      @(posedge clk) disable iff (!reset)
      rom_read_enable |-> (issue_cnt < n_r)
   );

endmodule
